// File: rtl/q824_pkg.sv
// Q8.24 fixed-point constants and FSM encoding shared by the iterative multiplier and divider.
// No logic; pure declarations plus a two's-complement magnitude helper.
package q824_pkg;

    localparam int          Q824_FRAC = 24;
    localparam logic [31:0] Q824_ONE  = 32'h0100_0000;
    localparam logic [31:0] Q824_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] Q824_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } q824_state_e;

    // |0x80000000| comes out as 0x80000000, read as unsigned 2^31.
    function automatic logic [31:0] q824_abs(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/q824_sat.sv
// Signed clamp of {sign, unsigned magnitude} into Q8.24; purely combinational, zero latency.
// No handshake: the caller registers q/sat when its result is final.
module q824_sat
    import q824_pkg::*;
(
    input  logic        neg,
    input  logic [63:0] mag,
    output logic [31:0] q,
    output logic        sat
);

    always_comb begin
        q   = mag[31:0];
        sat = 1'b0;
        if (!neg && (mag > {32'd0, Q824_MAX})) begin
            q   = Q824_MAX;
            sat = 1'b1;
        end else if (neg && (mag >= {32'd0, Q824_MIN})) begin
            q   = Q824_MIN;
            sat = 1'b1;
        end else if (neg) begin
            // A zero magnitude negates back to zero, so there is no negative zero.
            q = ~mag[31:0] + 32'd1;
        end
    end

endmodule

// File: rtl/mul_q824_seq.sv
// Sequential signed Q8.24 multiply q = sat((a*b) >> 24); latency 32/BITS_PER_CYCLE cycles from accept to out_valid.
// Operands are taken only in IDLE; the result is held in DONE until out_ready. MUL_Q824_ROUND_EN selects round-half-away.
module mul_q824_seq
    import q824_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] q,
    output logic        sat
);

    localparam int NCHUNK = 32 / BITS_PER_CYCLE;
`ifdef MUL_Q824_ROUND_EN
    localparam logic [63:0] RND_HALF = {32'd0, Q824_ONE >> 1};
`else
    localparam logic [63:0] RND_HALF = 64'd0;
`endif

    q824_state_e state_q, state_d;
    logic [63:0] a_sh_q, a_sh_d;
    logic [31:0] b_sh_q, b_sh_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] q_q, q_d;
    logic        sat_q, sat_d;

    logic [63:0] chunk_prod;
    logic [63:0] acc_fin;
    logic [63:0] mag;
    logic [31:0] sat_q_w;
    logic        sat_w;

    q824_sat u_sat (
        .neg (neg_q),
        .mag (mag),
        .q   (sat_q_w),
        .sat (sat_w)
    );

    // The multiplicand is pre-shifted each cycle so each chunk adds at its own weight.
    always_comb begin
        chunk_prod = 64'(b_sh_q[BITS_PER_CYCLE-1:0]) * a_sh_q;
        acc_fin    = acc_q + chunk_prod;
        mag        = (acc_fin + RND_HALF) >> Q824_FRAC;

        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        q_d         = q_q;
        sat_d       = sat_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d     = {32'd0, q824_abs(a)};
                    b_sh_d     = q824_abs(b);
                    neg_d      = a[31] ^ b[31];
                    acc_d      = 64'd0;
                    cnt_d      = 6'd0;
                    in_ready_d = 1'b0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d  = acc_fin;
                a_sh_d = a_sh_q << BITS_PER_CYCLE;
                b_sh_d = b_sh_q >> BITS_PER_CYCLE;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'(NCHUNK - 1)) begin
                    q_d         = sat_q_w;
                    sat_d       = sat_w;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= 64'd0;
            b_sh_q      <= 32'd0;
            acc_q       <= 64'd0;
            cnt_q       <= 6'd0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= 32'd0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_mul_q824_seq.sv
// Bench for mul_q824_seq at BITS_PER_CYCLE=1 and 4: vector table, random model vectors, stall and mid-op reset.
module tb_mul_q824_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic [31:0] a_i       [2];
    logic [31:0] b_i       [2];
    logic        out_ready [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic [31:0] q_o       [2];
    logic        sat_o     [2];

    always #5 clk = ~clk;

    mul_q824_seq #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_i[0]), .b(b_i[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .q(q_o[0]), .sat(sat_o[0])
    );

    mul_q824_seq #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_i[1]), .b(b_i[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .q(q_o[1]), .sat(sat_o[1])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        sat;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[14];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] aa, bb, p, m;
        logic        neg;
        aa  = {32'd0, a};
        bb  = {32'd0, b};
        if (a[31]) aa = 64'h1_0000_0000 - aa;
        if (b[31]) bb = 64'h1_0000_0000 - bb;
        neg = a[31] ^ b[31];
        p   = aa * bb;
`ifdef MUL_Q824_ROUND_EN
        p   = p + 64'h0080_0000;
`endif
        m   = p >> 24;
        if (!neg && m > 64'h7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
        if (neg && m >= 64'h8000_0000) return {1'b1, 32'h8000_0000};
        return {1'b0, neg ? (~m[31:0] + 32'd1) : m[31:0]};
    endfunction

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic exp_sat, input bit hold,
                          input string name);
        int   lat;
        int   guard;
        int   want_lat;
        vec_t e;
        want_lat = (d == 0) ? 32 : 8;
        guard = 0;
        while (!in_ready[d] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk({name, " in_ready"}, 64'(in_ready[d]), 64'd1);
        out_ready[d] = !hold;
        in_valid[d]  = 1'b1;
        a_i[d]       = a;
        b_i[d]       = b;
        e.a = a; e.b = b; e.q = exp_q; e.sat = exp_sat;
        sb.push_back(e);
        @(posedge clk);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            in_valid[d] = 1'b0;
            a_i[d]      = $urandom;
            b_i[d]      = $urandom;
            if (out_valid[d]) break;
            @(posedge clk);
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(want_lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, " q"}, 64'(q_o[d]), 64'(e.q));
            chk({name, " sat"}, 64'(sat_o[d]), 64'(e.sat));
        end
        if (hold) begin
            // Stalled result must not move, and operand pulses must not be taken.
            for (int i = 0; i < 5; i++) begin
                in_valid[d] = 1'b1;
                a_i[d]      = 32'h0100_0000;
                b_i[d]      = 32'h0100_0000;
                @(posedge clk);
                @(negedge clk);
                in_valid[d] = 1'b0;
                chk({name, " stall out_valid"}, 64'(out_valid[d]), 64'd1);
                chk({name, " stall q"}, 64'(q_o[d]), 64'(exp_q));
                chk({name, " stall sat"}, 64'(sat_o[d]), 64'(exp_sat));
                chk({name, " stall in_ready"}, 64'(in_ready[d]), 64'd0);
            end
            out_ready[d] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk({name, " out_valid drop"}, 64'(out_valid[d]), 64'd0);
        chk({name, " idle in_ready"}, 64'(in_ready[d]), 64'd1);
        chk({name, " q retained"}, 64'(q_o[d]), 64'(exp_q));
    endtask

    task automatic reset_mid_busy(input int d);
        in_valid[d] = 1'b1;
        a_i[d]      = 32'h6400_0000;
        b_i[d]      = 32'h6400_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy in_ready", 64'(in_ready[d]), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst out_valid", 64'(out_valid[d]), 64'd0);
        chk("rst q", 64'(q_o[d]), 64'd0);
        chk("rst sat", 64'(sat_o[d]), 64'd0);
        chk("rst in_ready", 64'(in_ready[d]), 64'd1);
        run_op(d, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 1'b0, 1'b0, "post-rst 1*1");
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [32:0] m;

        tbl[0]  = '{32'h0180_0000, 32'h0200_0000, 32'h0300_0000, 1'b0};
        tbl[1]  = '{32'hFE80_0000, 32'h0200_0000, 32'hFD00_0000, 1'b0};
        tbl[2]  = '{32'hFF00_0000, 32'hFF00_0000, 32'h0100_0000, 1'b0};
        tbl[3]  = '{32'h6400_0000, 32'h6400_0000, 32'h7FFF_FFFF, 1'b1};
        tbl[4]  = '{32'h6400_0000, 32'h9C00_0000, 32'h8000_0000, 1'b1};
        tbl[5]  = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        tbl[6]  = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[8]  = '{32'h8000_0000, 32'h0100_0000, 32'h8000_0000, 1'b1};
        tbl[9]  = '{32'h7FFF_FFFF, 32'h0100_0000, 32'h7FFF_FFFF, 1'b0};
        tbl[10] = '{32'h8000_0000, 32'hFF00_0000, 32'h7FFF_FFFF, 1'b1};
        tbl[11] = '{32'h0040_0000, 32'hFC00_0000, 32'hFF00_0000, 1'b0};
`ifdef MUL_Q824_ROUND_EN
        tbl[12] = '{32'h0000_0001, 32'h0080_0000, 32'h0000_0001, 1'b0};
        tbl[13] = '{32'hFFFF_FFFF, 32'h0080_0000, 32'hFFFF_FFFF, 1'b0};
`else
        tbl[12] = '{32'h0000_0001, 32'h0080_0000, 32'h0000_0000, 1'b0};
        tbl[13] = '{32'hFFFF_FFFF, 32'h0080_0000, 32'h0000_0000, 1'b0};
`endif

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            a_i[d]       = 32'd0;
            b_i[d]       = 32'd0;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("reset in_ready", 64'(in_ready[d]), 64'd1);
            chk("reset out_valid", 64'(out_valid[d]), 64'd0);
            chk("reset q", 64'(q_o[d]), 64'd0);
            chk("reset sat", 64'(sat_o[d]), 64'd0);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 14; i++)
                run_op(d, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].sat, 1'b0, $sformatf("dut%0d vec%0d", d, i));
            for (int i = 0; i < 8; i++) begin
                ra = $urandom;
                rb = $urandom >> $urandom_range(0, 31);
                if (i[0]) rb = ~rb;
                m = model(ra, rb);
                run_op(d, ra, rb, m[31:0], m[32], 1'b0, $sformatf("dut%0d rnd%0d", d, i));
            end
            run_op(d, 32'h6400_0000, 32'h9C00_0000, 32'h8000_0000, 1'b1, 1'b1, $sformatf("dut%0d stall", d));
            reset_mid_busy(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
